// File: rtl/i2c_line_conditioner.sv
// rtl/i2c_line_conditioner.sv - SCL/SDA synchroniser, spike filter, edge and START/STOP detector
// Optional macro I2C_GLITCH_COUNT_EN adds the saturating glitch_count output.
module i2c_line_conditioner #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3,
  parameter int CNT_WIDTH     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_o,
  output logic       sda_o,
  output logic       scl_rise,
  output logic       scl_fall,
  output logic       start_det,
  output logic       stop_det,
  output logic       bus_busy
`ifdef I2C_GLITCH_COUNT_EN
  ,
  output logic [7:0] glitch_count
`endif
);

  localparam logic [CNT_WIDTH-1:0] LP_CNT_LAST = CNT_WIDTH'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic [CNT_WIDTH-1:0]   r_scl_cnt;
  logic [CNT_WIDTH-1:0]   r_sda_cnt;
  logic                   r_scl_o;
  logic                   r_sda_o;
  logic                   r_scl_rise;
  logic                   r_scl_fall;
  logic                   r_start;
  logic                   r_stop;
  logic                   r_busy;

  logic w_s_scl;
  logic w_s_sda;
  logic w_scl_diff;
  logic w_sda_diff;
  logic w_scl_upd;
  logic w_sda_upd;
  logic w_start;
  logic w_stop;

  // Idle bus is high, so the synchronisers reset to 1 to avoid a false edge at reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
    end
  end

  assign w_s_scl    = r_scl_sync[SYNC_STAGES-1];
  assign w_s_sda    = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_diff = (w_s_scl != r_scl_o);
  assign w_sda_diff = (w_s_sda != r_sda_o);
  assign w_scl_upd  = ena && w_scl_diff && (r_scl_cnt == LP_CNT_LAST);
  assign w_sda_upd  = ena && w_sda_diff && (r_sda_cnt == LP_CNT_LAST);

  // A bus condition needs SCL stable and high; a simultaneous SCL edge voids it.
  assign w_start = w_sda_upd && !w_s_sda && !w_scl_upd && r_scl_o;
  assign w_stop  = w_sda_upd &&  w_s_sda && !w_scl_upd && r_scl_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_cnt <= '0;
      r_sda_cnt <= '0;
      r_scl_o   <= 1'b1;
      r_sda_o   <= 1'b1;
    end else begin
      if (!ena || !w_scl_diff || w_scl_upd) r_scl_cnt <= '0;
      else                                   r_scl_cnt <= r_scl_cnt + 1'b1;
      if (!ena || !w_sda_diff || w_sda_upd) r_sda_cnt <= '0;
      else                                   r_sda_cnt <= r_sda_cnt + 1'b1;
      if (w_scl_upd) r_scl_o <= w_s_scl;
      if (w_sda_upd) r_sda_o <= w_s_sda;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_rise <= 1'b0;
      r_scl_fall <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
      r_busy     <= 1'b0;
    end else if (!ena) begin
      r_scl_rise <= 1'b0;
      r_scl_fall <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_scl_rise <= w_scl_upd &&  w_s_scl;
      r_scl_fall <= w_scl_upd && !w_s_scl;
      r_start    <= w_start;
      r_stop     <= w_stop;
      if (r_start)     r_busy <= 1'b1;
      else if (r_stop) r_busy <= 1'b0;
    end
  end

`ifdef I2C_GLITCH_COUNT_EN
  logic       w_scl_glitch;
  logic       w_sda_glitch;
  logic [7:0] r_glitch_count;

  // A glitch is a partial count abandoned because the level returned.
  assign w_scl_glitch = ena && !w_scl_diff && (r_scl_cnt != '0);
  assign w_sda_glitch = ena && !w_sda_diff && (r_sda_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_glitch_count <= 8'd0;
    end else if ((w_scl_glitch || w_sda_glitch) && (r_glitch_count != 8'hFF)) begin
      r_glitch_count <= r_glitch_count + 8'd1;
    end
  end

  assign glitch_count = r_glitch_count;
`endif

  assign scl_o     = r_scl_o;
  assign sda_o     = r_sda_o;
  assign scl_rise  = r_scl_rise;
  assign scl_fall  = r_scl_fall;
  assign start_det = r_start;
  assign stop_det  = r_stop;
  assign bus_busy  = r_busy;

endmodule

// File: tb/tb_i2c_line_conditioner.sv
// tb/tb_i2c_line_conditioner.sv - randomized self-checking bench for i2c_line_conditioner
module tb_i2c_line_conditioner;
  localparam int S  = 2;
  localparam int F  = 3;
  localparam int CW = 2;
  localparam int H  = F + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic scl_in = 1'b1;
  logic sda_in = 1'b1;
  logic scl_o, sda_o, scl_rise, scl_fall, start_det, stop_det, bus_busy;
`ifdef I2C_GLITCH_COUNT_EN
  logic [7:0] glitch_count;
`endif

  always #5 clk = ~clk;

  i2c_line_conditioner #(.SYNC_STAGES(S), .FILTER_CYCLES(F), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .scl_in(scl_in), .sda_in(sda_in),
    .scl_o(scl_o), .sda_o(sda_o), .scl_rise(scl_rise), .scl_fall(scl_fall),
    .start_det(start_det), .stop_det(stop_det), .bus_busy(bus_busy)
`ifdef I2C_GLITCH_COUNT_EN
    , .glitch_count(glitch_count)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: filtered level flips once the synchronised level has
  // disagreed with it for F consecutive enabled cycles.
  bit q_scl[$];
  bit q_sda[$];
  bit h_en[H];
  bit h_scl[H];
  bit h_sda[H];
  bit m_scl, m_sda, m_rise, m_fall, m_start, m_stop, m_busy;
  int m_gc;
  bit s_scl, s_sda, ch_scl, ch_sda, g;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_scl = {};
      q_sda = {};
      for (int i = 0; i < S; i++) begin
        q_scl.push_back(1'b1);
        q_sda.push_back(1'b1);
      end
      for (int i = 0; i < H; i++) begin
        h_en[i] = 1'b0; h_scl[i] = 1'b1; h_sda[i] = 1'b1;
      end
      m_scl = 1; m_sda = 1; m_rise = 0; m_fall = 0; m_start = 0; m_stop = 0; m_busy = 0; m_gc = 0;
    end else begin
      s_scl = q_scl.pop_front();
      s_sda = q_sda.pop_front();
      q_scl.push_back(scl_in);
      q_sda.push_back(sda_in);
      for (int i = H - 1; i > 0; i--) begin
        h_en[i] = h_en[i-1]; h_scl[i] = h_scl[i-1]; h_sda[i] = h_sda[i-1];
      end
      h_en[0] = ena; h_scl[0] = s_scl; h_sda[0] = s_sda;
      ch_scl = 1; ch_sda = 1;
      for (int i = 0; i < F; i++) begin
        if (!h_en[i] || h_scl[i] == m_scl) ch_scl = 0;
        if (!h_en[i] || h_sda[i] == m_sda) ch_sda = 0;
      end
      g = (h_en[0] && h_en[1] && h_scl[0] == m_scl && h_scl[1] != m_scl) ||
          (h_en[0] && h_en[1] && h_sda[0] == m_sda && h_sda[1] != m_sda);
      if (!ena) m_busy = 0;
      else if (m_start) m_busy = 1;
      else if (m_stop) m_busy = 0;
      if (ena) begin
        m_rise  = ch_scl && !m_scl;
        m_fall  = ch_scl && m_scl;
        m_start = ch_sda && m_sda && !ch_scl && m_scl;
        m_stop  = ch_sda && !m_sda && !ch_scl && m_scl;
      end else begin
        m_rise = 0; m_fall = 0; m_start = 0; m_stop = 0;
      end
      if (ch_scl) m_scl = !m_scl;
      if (ch_sda) m_sda = !m_sda;
      if (g && m_gc < 255) m_gc++;
    end
  end

  bit chk_on = 0;
  int c_rise = 0, c_fall = 0, c_start = 0, c_stop = 0, c_busy_low = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      check("scl_o", scl_o, m_scl);
      check("sda_o", sda_o, m_sda);
      check("scl_rise", scl_rise, m_rise);
      check("scl_fall", scl_fall, m_fall);
      check("start_det", start_det, m_start);
      check("stop_det", stop_det, m_stop);
      check("bus_busy", bus_busy, m_busy);
`ifdef I2C_GLITCH_COUNT_EN
      check("glitch_count", glitch_count, m_gc);
`endif
      c_rise     += int'(scl_rise);
      c_fall     += int'(scl_fall);
      c_start    += int'(start_det);
      c_stop     += int'(stop_det);
      c_busy_low += int'(!bus_busy);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  int b_rise, b_fall, b_start, b_stop, b_low, lat;

  task automatic snap();
    b_rise = c_rise; b_fall = c_fall; b_start = c_start; b_stop = c_stop; b_low = c_busy_low;
  endtask

  initial begin
    tick(3);
    rst_n = 1;
    chk_on = 1;

    // idle after reset
    snap();
    tick(20);
    check("idle_strobes", (c_rise - b_rise) + (c_fall - b_fall) + (c_start - b_start) + (c_stop - b_stop), 0);
    check("idle_busy", bus_busy, 0);

    // latency of a clean SCL fall
    scl_in = 0;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (scl_fall === 1'b1 && lat < 0) lat = i;
    end
    check("fall_latency", lat, S + F);
    check("scl_low", scl_o, 0);
    scl_in = 1;
    tick(10);

    // 2-cycle SDA spike with SCL high is rejected
    snap();
    sda_in = 0;
    tick(2);
    sda_in = 1;
    tick(10);
    check("spike_start", c_start - b_start, 0);
    check("spike_sda_o", sda_o, 1);
`ifdef I2C_GLITCH_COUNT_EN
    check("spike_glitch_count", glitch_count, 1);
`endif

    // START, nine clocks, STOP
    snap();
    sda_in = 0;
    tick(8);
    for (int i = 0; i < 9; i++) begin
      scl_in = 0; tick(8);
      scl_in = 1; tick(8);
    end
    check("txn_busy", bus_busy, 1);
    sda_in = 1;
    tick(10);
    check("txn_start", c_start - b_start, 1);
    check("txn_rise", c_rise - b_rise, 9);
    check("txn_fall", c_fall - b_fall, 9);
    check("txn_stop", c_stop - b_stop, 1);
    check("txn_idle", bus_busy, 0);

    // repeated START keeps the bus busy
    snap();
    sda_in = 0; tick(8);
    b_low = c_busy_low;
    scl_in = 0; tick(8);
    sda_in = 1; tick(8);
    scl_in = 1; tick(8);
    sda_in = 0; tick(8);
    check("rs_start", c_start - b_start, 2);
    check("rs_busy_gap", c_busy_low - b_low, 0);
    sda_in = 1; tick(10);

    // ena low mid-transaction
    sda_in = 0; tick(8);
    scl_in = 0; tick(8);
    ena = 0;
    tick(1);
    check("ena_busy", bus_busy, 0);
    snap();
    sda_in = 1; tick(4);
    scl_in = 1; tick(4);
    sda_in = 0; tick(4);
    scl_in = 0; tick(8);
    ena = 1;
    tick(8);
    check("ena_strobes", (c_rise - b_rise) + (c_fall - b_fall) + (c_start - b_start) + (c_stop - b_stop), 0);

    // reset while SCL low
    check("pre_rst_scl", scl_o, 0);
    rst_n = 0;
    #1;
    check("rst_scl_o", scl_o, 1);
    check("rst_sda_o", sda_o, 1);
    check("rst_busy", bus_busy, 0);
    tick(2);
    rst_n = 1;
    tick(12);
    scl_in = 1; sda_in = 1;
    tick(10);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(5) == 0) scl_in = ~scl_in;
      if ($urandom_range(5) == 0) sda_in = ~sda_in;
      if ($urandom_range(199) == 0) ena = ~ena;
      if ($urandom_range(599) == 0) begin
        rst_n = 0;
        tick($urandom_range(1, 3));
        rst_n = 1;
      end
      tick(1);
    end
    ena = 1;
    tick(10);

    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
